// File: rtl/i2c_reg_bank_arbiter_pkg.sv
// Shared types and constants for the I2C register bank / host arbiter.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } host_st_e;

  localparam logic I2C_DIR_WRITE = 1'b0;
  localparam logic I2C_DIR_READ  = 1'b1;

  localparam logic [7:0] OOR_RD_DEFAULT  = 8'hFF;
  localparam logic [7:0] REG_RST_DEFAULT = 8'h00;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } host_req_t;

  // 9-bit compare so NUM_REGS=256 covers the full address space
  function automatic logic addr_in_range(input logic [7:0] addr, input int num_regs);
    logic [8:0] w_lim;
    w_lim = num_regs[8:0];
    return ({1'b0, addr} < w_lim);
  endfunction

endpackage

// File: rtl/i2c_reg_bank_arbiter_if.sv
// Bus bundle between the register bank (slave) and its I2C slave / fabric host drivers (master).
interface i2c_reg_bank_arbiter_if;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_dir;
  logic       i2c_done;
  logic [7:0] i2c_rdata;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       i2c_wr_evt;
  logic [7:0] i2c_wr_evt_addr;

  modport slave (
    input  i2c_reg_addr, i2c_wdata, i2c_dir, i2c_done,
    input  host_req, host_we, host_addr, host_wdata,
    output i2c_rdata, host_ack, host_rdata, i2c_wr_evt, i2c_wr_evt_addr
  );

  modport master (
    output i2c_reg_addr, i2c_wdata, i2c_dir, i2c_done,
    output host_req, host_we, host_addr, host_wdata,
    input  i2c_rdata, host_ack, host_rdata, i2c_wr_evt, i2c_wr_evt_addr
  );
endinterface

// File: rtl/i2c_reg_bank_arbiter_done_strobe.sv
// Turns the I2C slave's multi-cycle transfer-done level into one write strobe per byte.
module i2c_done_strobe
  import i2c_pkg::*;
(
  input  logic mod_clk,
  input  logic mod_rst,
  input  logic i_done,
  input  logic i_dir,
  output logic o_wr
);

  logic r_done_d;

  always_ff @(posedge mod_clk) begin
    if (mod_rst) r_done_d <= 1'b0;
    else         r_done_d <= i_done;
  end

  // rising edge of done, master-write direction only
  assign o_wr = i_done & ~r_done_d & (i_dir == I2C_DIR_WRITE);

endmodule

// File: rtl/i2c_reg_bank_arbiter.sv
// Register bank shared by the I2C slave and a fabric host port; I2C writes win conflicts.
module i2c_reg_bank_arbiter
  import i2c_pkg::*;
#(
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] REG_RST_VAL = REG_RST_DEFAULT,
  parameter logic [7:0] OOR_RD_VAL  = OOR_RD_DEFAULT
) (
  input  logic                   mod_clk,
  input  logic                   mod_rst,
  i2c_reg_bank_arbiter_if.slave  bus
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0]    r_regs [NUM_REGS];
  logic [7:0]    r_i2c_rdata;
  logic          r_evt;
  logic [7:0]    r_evt_addr;
  host_st_e      r_state;
  host_req_t     r_req;
  logic          r_ack;
  logic [7:0]    r_host_rdata;

  logic          w_i2c_wr;
  logic          w_i2c_in_rng;
  logic          w_host_in_rng;
  logic          w_i2c_commit;
  logic          w_host_commit;
  logic [AW-1:0] w_i2c_idx;
  logic [AW-1:0] w_host_idx;
  logic [7:0]    w_i2c_rd;
  logic [7:0]    w_host_rd;

  i2c_done_strobe u_strobe (
    .mod_clk (mod_clk),
    .mod_rst (mod_rst),
    .i_done  (bus.i2c_done),
    .i_dir   (bus.i2c_dir),
    .o_wr    (w_i2c_wr)
  );

  assign w_i2c_in_rng  = addr_in_range(bus.i2c_reg_addr, NUM_REGS);
  assign w_host_in_rng = addr_in_range(r_req.addr, NUM_REGS);
  assign w_i2c_idx     = bus.i2c_reg_addr[AW-1:0];
  assign w_host_idx    = r_req.addr[AW-1:0];

  assign w_i2c_commit  = w_i2c_wr & w_i2c_in_rng;
  // a host write stalls on any I2C strobe, even to a different or invalid address
  assign w_host_commit = (r_state == ACCESS) & r_req.we & ~w_i2c_wr & w_host_in_rng;

  assign w_i2c_rd  = w_i2c_in_rng  ? r_regs[w_i2c_idx]  : OOR_RD_VAL;
  assign w_host_rd = w_host_in_rng ? r_regs[w_host_idx] : OOR_RD_VAL;

  always_ff @(posedge mod_clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (mod_rst)
        r_regs[i] <= REG_RST_VAL;
      else if (w_i2c_commit && w_i2c_idx == AW'(i))
        r_regs[i] <= bus.i2c_wdata;
      else if (w_host_commit && w_host_idx == AW'(i))
        r_regs[i] <= r_req.wdata;
    end
  end

  // Reads sample the array before this cycle's write lands
  always_ff @(posedge mod_clk) begin
    if (mod_rst) begin
      r_i2c_rdata <= REG_RST_VAL;
      r_evt       <= 1'b0;
      r_evt_addr  <= 8'h00;
    end else begin
      r_i2c_rdata <= w_i2c_rd;
      r_evt       <= w_i2c_commit;
      if (w_i2c_commit) r_evt_addr <= bus.i2c_reg_addr;
    end
  end

  always_ff @(posedge mod_clk) begin
    if (mod_rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_ack        <= 1'b0;
      r_host_rdata <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.host_req) begin
            r_req   <= '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_req.we) begin
            r_host_rdata <= w_host_rd;
            r_ack        <= 1'b1;
            r_state      <= ACK;
          end else if (!w_i2c_wr) begin
            r_ack   <= 1'b1;
            r_state <= ACK;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.i2c_rdata       = r_i2c_rdata;
  assign bus.host_ack        = r_ack;
  assign bus.host_rdata      = r_host_rdata;
  assign bus.i2c_wr_evt      = r_evt;
  assign bus.i2c_wr_evt_addr = r_evt_addr;

endmodule

// File: tb/tb_i2c_reg_bank_arbiter.sv
// Directed bench for the I2C register bank arbiter: reset, I2C writes, collisions, out-of-range, reset abort.
module tb_i2c_reg_bank_arbiter;

  logic mod_clk = 1'b0;
  logic mod_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  i2c_reg_bank_arbiter_if bus ();

  i2c_reg_bank_arbiter #(
    .NUM_REGS    (16),
    .REG_RST_VAL (8'h00),
    .OOR_RD_VAL  (8'hFF)
  ) dut (
    .mod_clk (mod_clk),
    .mod_rst (mod_rst),
    .bus     (bus)
  );

  always #5 mod_clk = ~mod_clk;

  task automatic tick;
    @(posedge mod_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one host access; lat is the number of edges until ack (0 = timed out)
  task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rd);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
    lat = 0;
    rd  = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.host_ack) begin
        lat = i;
        rd  = bus.host_rdata;
        break;
      end
    end
    bus.host_req = 1'b0;
    tick();
  endtask

  initial begin
    int         lat;
    logic [7:0] rd;
    int         evts;

    bus.i2c_reg_addr = 8'h03;
    bus.i2c_wdata    = 8'h00;
    bus.i2c_dir      = 1'b0;
    bus.i2c_done     = 1'b0;
    bus.host_req     = 1'b0;
    bus.host_we      = 1'b0;
    bus.host_addr    = 8'h00;
    bus.host_wdata   = 8'h00;

    // reset
    tick(); tick();
    mod_rst = 1'b0;
    chk("rst_ack",      bus.host_ack,        1'b0);
    chk("rst_hrdata",   bus.host_rdata,      8'h00);
    chk("rst_evt",      bus.i2c_wr_evt,      1'b0);
    chk("rst_evt_addr", bus.i2c_wr_evt_addr, 8'h00);
    chk("rst_i2c_rd",   bus.i2c_rdata,       8'h00);
    host_access(1'b0, 8'h03, 8'h00, lat, rd);
    chk("rst_rd3_lat",  lat, 2);
    chk("rst_rd3_data", rd,  8'h00);

    // I2C write addr 5 = A5, done held 10 cycles
    bus.i2c_reg_addr = 8'h05;
    bus.i2c_wdata    = 8'hA5;
    bus.i2c_dir      = 1'b0;
    bus.i2c_done     = 1'b1;
    tick();
    chk("wr_evt",       bus.i2c_wr_evt,      1'b1);
    chk("wr_evt_addr",  bus.i2c_wr_evt_addr, 8'h05);
    chk("wr_rd_n1",     bus.i2c_rdata,       8'h00);
    tick();
    chk("wr_evt_end",   bus.i2c_wr_evt,      1'b0);
    chk("wr_rd_n2",     bus.i2c_rdata,       8'hA5);
    evts = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.i2c_wr_evt) evts++;
    end
    chk("wr_single_evt", evts, 0);
    bus.i2c_done = 1'b0;
    tick();
    host_access(1'b0, 8'h05, 8'h00, lat, rd);
    chk("wr_rd5_data", rd, 8'hA5);

    // I2C read direction: no write, no event
    bus.i2c_reg_addr = 8'h06;
    bus.i2c_wdata    = 8'h77;
    bus.i2c_dir      = 1'b1;
    bus.i2c_done     = 1'b1;
    evts = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.i2c_wr_evt) evts++;
    end
    bus.i2c_done = 1'b0;
    tick();
    chk("rdir_evts",     evts, 0);
    chk("rdir_evt_addr", bus.i2c_wr_evt_addr, 8'h05);
    chk("rdir_i2c_rd",   bus.i2c_rdata, 8'h00);
    host_access(1'b0, 8'h06, 8'h00, lat, rd);
    chk("rdir_rd6", rd, 8'h00);

    // Collision: host write 5=3C, I2C strobe 5=5A lands in the host ACCESS cycle
    bus.i2c_dir      = 1'b0;
    bus.i2c_reg_addr = 8'h05;
    bus.host_req     = 1'b1;
    bus.host_we      = 1'b1;
    bus.host_addr    = 8'h05;
    bus.host_wdata   = 8'h3C;
    tick();
    chk("col_ack_c1", bus.host_ack, 1'b0);
    bus.i2c_wdata = 8'h5A;
    bus.i2c_done  = 1'b1;
    tick();
    chk("col_ack_c2",   bus.host_ack,   1'b0);
    chk("col_evt",      bus.i2c_wr_evt, 1'b1);
    chk("col_i2c_old",  bus.i2c_rdata,  8'hA5);
    tick();
    chk("col_ack_c3",   bus.host_ack,   1'b1);
    chk("col_i2c_mid",  bus.i2c_rdata,  8'h5A);
    bus.host_req = 1'b0;
    tick();
    chk("col_ack_end",  bus.host_ack,   1'b0);
    chk("col_i2c_fin",  bus.i2c_rdata,  8'h3C);
    bus.i2c_done = 1'b0;
    tick();
    host_access(1'b0, 8'h05, 8'h00, lat, rd);
    chk("col_rd5", rd, 8'h3C);

    // Out of range
    host_access(1'b1, 8'h20, 8'h11, lat, rd);
    chk("oor_wr_lat", lat, 2);
    host_access(1'b0, 8'h20, 8'h00, lat, rd);
    chk("oor_rd_lat",  lat, 2);
    chk("oor_rd_data", rd,  8'hFF);
    host_access(1'b0, 8'h00, 8'h00, lat, rd);
    chk("oor_alias0",  rd,  8'h00);
    bus.i2c_reg_addr = 8'h20;
    bus.i2c_wdata    = 8'h99;
    tick(); tick();
    chk("oor_i2c_rd", bus.i2c_rdata, 8'hFF);
    bus.i2c_done = 1'b1;
    evts = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.i2c_wr_evt) evts++;
    end
    bus.i2c_done = 1'b0;
    tick();
    chk("oor_i2c_evts",   evts, 0);
    chk("oor_evt_addr",   bus.i2c_wr_evt_addr, 8'h05);
    host_access(1'b0, 8'h00, 8'h00, lat, rd);
    chk("oor_alias0_i2c", rd, 8'h00);

    // Reset during ACCESS
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'h07;
    bus.host_wdata = 8'hE7;
    tick();
    mod_rst = 1'b1;
    tick();
    bus.host_req = 1'b0;
    mod_rst = 1'b0;
    chk("rsta_ack0", bus.host_ack, 1'b0);
    tick();
    chk("rsta_ack1", bus.host_ack, 1'b0);
    tick();
    chk("rsta_ack2", bus.host_ack, 1'b0);
    host_access(1'b0, 8'h07, 8'h00, lat, rd);
    chk("rsta_lat", lat, 2);
    chk("rsta_rd7", rd,  8'h00);
    host_access(1'b0, 8'h05, 8'h00, lat, rd);
    chk("rsta_rd5", rd,  8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
